// File: rtl/rect_draw_ctrl.sv
// rtl/rect_draw_ctrl.sv - clipped rectangle fill, one pixel per clock in raster order.
// Optional full-bitmap clear via cmd_clear when RECT_DRAW_CLEAR_EN is defined.
module rect_draw_ctrl #(
  parameter int X_MAX = 320,
  parameter int Y_MAX = 240
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [8:0] cmd_x0,
  input  logic [7:0] cmd_y0,
  input  logic [8:0] cmd_w,
  input  logic [7:0] cmd_h,
  input  logic [2:0] cmd_color,
`ifdef RECT_DRAW_CLEAR_EN
  input  logic       cmd_clear,
`endif
  output logic [8:0] x,
  output logic [7:0] y,
  output logic [2:0] color,
  output logic       wr_en,
  output logic       busy,
  output logic       done
);

  localparam logic [9:0] XM = 10'(X_MAX);
  localparam logic [9:0] YM = 10'(Y_MAX);

  typedef enum logic [1:0] {IDLE, DRAW, DONE} state_t;

  state_t     state;
  logic [9:0] ax0, ay0, ew, eh;
  logic [8:0] x_last, x_start, x_end;
  logic [7:0] y_last, y_end;

  // Clipping is done in 10 bits so x0+w never wraps past the bitmap edge.
  always_comb begin
    ax0 = {1'b0, cmd_x0};
    ay0 = {2'b00, cmd_y0};
    ew  = (ax0 >= XM) ? 10'd0 :
          (({1'b0, cmd_w} < (XM - ax0)) ? {1'b0, cmd_w} : (XM - ax0));
    eh  = (ay0 >= YM) ? 10'd0 :
          (({2'b00, cmd_h} < (YM - ay0)) ? {2'b00, cmd_h} : (YM - ay0));
`ifdef RECT_DRAW_CLEAR_EN
    if (cmd_clear) begin
      ax0 = 10'd0;
      ay0 = 10'd0;
      ew  = XM;
      eh  = YM;
    end
`endif
    x_last = 9'(ax0 + ew - 10'd1);
    y_last = 8'(ay0 + eh - 10'd1);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      x         <= '0;
      y         <= '0;
      color     <= '0;
      wr_en     <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      cmd_ready <= 1'b0;
      x_start   <= '0;
      x_end     <= '0;
      y_end     <= '0;
    end else begin
      case (state)
        IDLE: begin
          done  <= 1'b0;
          wr_en <= 1'b0;
          if (cmd_valid && cmd_ready) begin
            busy      <= 1'b1;
            cmd_ready <= 1'b0;
            color     <= cmd_color;
            if (ew == 10'd0 || eh == 10'd0) begin
              state <= DONE;
              done  <= 1'b1;
            end else begin
              state   <= DRAW;
              wr_en   <= 1'b1;
              x       <= ax0[8:0];
              y       <= ay0[7:0];
              x_start <= ax0[8:0];
              x_end   <= x_last;
              y_end   <= y_last;
            end
          end else begin
            cmd_ready <= 1'b1;
          end
        end
        DRAW: begin
          if (x == x_end) begin
            if (y == y_end) begin
              state <= DONE;
              wr_en <= 1'b0;
              done  <= 1'b1;
            end else begin
              x <= x_start;
              y <= y + 8'd1;
            end
          end else begin
            x <= x + 9'd1;
          end
        end
        DONE: begin
          state     <= IDLE;
          done      <= 1'b0;
          busy      <= 1'b0;
          cmd_ready <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rect_draw_ctrl.sv
// tb/tb_rect_draw_ctrl.sv - randomized self-checking bench for rect_draw_ctrl.
module tb_rect_draw_ctrl;

  localparam int XM = 320;
  localparam int YM = 240;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic [8:0] cmd_x0 = '0;
  logic [7:0] cmd_y0 = '0;
  logic [8:0] cmd_w = '0;
  logic [7:0] cmd_h = '0;
  logic [2:0] cmd_color = '0;
`ifdef RECT_DRAW_CLEAR_EN
  logic       cmd_clear = 1'b0;
`endif
  logic [8:0] x;
  logic [7:0] y;
  logic [2:0] color;
  logic       wr_en, busy, done;

  rect_draw_ctrl #(.X_MAX(XM), .Y_MAX(YM)) dut (
    .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_x0(cmd_x0), .cmd_y0(cmd_y0), .cmd_w(cmd_w), .cmd_h(cmd_h),
    .cmd_color(cmd_color),
`ifdef RECT_DRAW_CLEAR_EN
    .cmd_clear(cmd_clear),
`endif
    .x(x), .y(y), .color(color), .wr_en(wr_en), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit ready, busy, done, wr;
    int x, y, c;
  } exp_t;

  exp_t q[$];
  exp_t cur;
  bit   acc_evt = 0;
  int   n_chk = 0, n_fail = 0;
  int   log_x[$], log_y[$], log_c[$];
  int   done_cnt = 0, busy_cnt = 0;

  function automatic exp_t mk(bit r, bit b, bit d, bit w, int xx, int yy, int cc);
    exp_t e;
    e.ready = r; e.busy = b; e.done = d; e.wr = w; e.x = xx; e.y = yy; e.c = cc;
    return e;
  endfunction

  // Expected per-cycle outputs after an accepted command: the clipped pixels, then the done cycle.
  task automatic build(int x0, int y0, int w, int h, int c, bit clr);
    int ew, eh;
    if (clr) begin
      x0 = 0; y0 = 0; ew = XM; eh = YM;
    end else begin
      ew = (x0 >= XM) ? 0 : ((w < XM - x0) ? w : XM - x0);
      eh = (y0 >= YM) ? 0 : ((h < YM - y0) ? h : YM - y0);
    end
    for (int yy = 0; yy < eh; yy++)
      for (int xx = 0; xx < ew; xx++)
        q.push_back(mk(0, 1, 0, 1, x0 + xx, y0 + yy, c));
    q.push_back(mk(0, 1, 1, 0, 0, 0, 0));
  endtask

  always @(posedge clk) begin
    bit clr;
    clr = 0;
`ifdef RECT_DRAW_CLEAR_EN
    clr = cmd_clear;
`endif
    acc_evt = 0;
    if (!reset) begin
      q.delete();
      cur = mk(0, 0, 0, 0, 0, 0, 0);
    end else if (q.size() > 0) begin
      cur = q.pop_front();
    end else if (cur.ready && cmd_valid) begin
      build(int'(cmd_x0), int'(cmd_y0), int'(cmd_w), int'(cmd_h), int'(cmd_color), clr);
      acc_evt = 1;
      cur = q.pop_front();
    end else begin
      cur = mk(1, 0, 0, 0, 0, 0, 0);
    end
  end

  task automatic chk(string name, int act, int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  always @(posedge clk) begin
    #2;
    chk("cmd_ready", int'(cmd_ready), int'(cur.ready));
    chk("busy", int'(busy), int'(cur.busy));
    chk("done", int'(done), int'(cur.done));
    chk("wr_en", int'(wr_en), int'(cur.wr));
    if (cur.wr) begin
      chk("x", int'(x), cur.x);
      chk("y", int'(y), cur.y);
      chk("color", int'(color), cur.c);
    end
    if (!reset) begin
      chk("rst_x", int'(x), 0);
      chk("rst_y", int'(y), 0);
      chk("rst_color", int'(color), 0);
    end
    if (wr_en) begin
      log_x.push_back(int'(x)); log_y.push_back(int'(y)); log_c.push_back(int'(color));
    end
    if (done) done_cnt++;
    if (busy) busy_cnt++;
  end

  task automatic clear_logs();
    log_x.delete(); log_y.delete(); log_c.delete();
    done_cnt = 0; busy_cnt = 0;
  endtask

  task automatic send(int x0, int y0, int w, int h, int c, bit clr);
    bit got;
    got = 0;
    @(negedge clk);
    cmd_x0 = 9'(x0); cmd_y0 = 8'(y0); cmd_w = 9'(w); cmd_h = 8'(h); cmd_color = 3'(c);
`ifdef RECT_DRAW_CLEAR_EN
    cmd_clear = clr;
`endif
    cmd_valid = 1'b1;
    for (int i = 0; i < 300; i++) begin
      @(posedge clk); #1;
      if (acc_evt) begin got = 1; break; end
    end
    if (!got) chk("accept_timeout", 0, 1);
    @(negedge clk);
    cmd_valid = 1'b0;
`ifdef RECT_DRAW_CLEAR_EN
    cmd_clear = 1'b0;
`endif
  endtask

  task automatic wait_idle();
    bit ok;
    ok = 0;
    for (int i = 0; i < 90000; i++) begin
      @(posedge clk); #3;
      if (q.size() == 0 && cur.ready) begin ok = 1; break; end
    end
    if (!ok) chk("idle_timeout", 0, 1);
  endtask

  initial begin
    int ex_x[6], ex_y[6];
    ex_x = '{10, 11, 12, 10, 11, 12};
    ex_y = '{5, 5, 5, 6, 6, 6};

    repeat (3) @(negedge clk);
    reset = 1'b1;
    repeat (2) @(posedge clk);

    // Basic 3x2 fill with hand-computed write list.
    clear_logs();
    send(10, 5, 3, 2, 5, 0);
    wait_idle();
    chk("basic_count", log_x.size(), 6);
    for (int i = 0; i < 6 && i < log_x.size(); i++) begin
      chk("basic_x", log_x[i], ex_x[i]);
      chk("basic_y", log_y[i], ex_y[i]);
      chk("basic_c", log_c[i], 5);
    end
    chk("basic_done", done_cnt, 1);
    chk("basic_busy", busy_cnt, 7);

    // Clipping at bottom-right corner.
    clear_logs();
    send(318, 239, 10, 4, 2, 0);
    wait_idle();
    chk("clip_count", log_x.size(), 2);
    if (log_x.size() == 2) begin
      chk("clip_x0", log_x[0], 318); chk("clip_y0", log_y[0], 239);
      chk("clip_x1", log_x[1], 319); chk("clip_y1", log_y[1], 239);
    end

    // Empty commands: zero width, and origin past the right edge.
    clear_logs();
    send(20, 20, 0, 5, 1, 0);
    wait_idle();
    chk("w0_writes", log_x.size(), 0);
    chk("w0_done", done_cnt, 1);
    chk("w0_busy", busy_cnt, 1);
    clear_logs();
    send(400, 10, 5, 5, 1, 0);
    wait_idle();
    chk("x400_writes", log_x.size(), 0);
    chk("x400_busy", busy_cnt, 1);

    // cmd_valid held with changing fields while drawing.
    clear_logs();
    send(2, 3, 4, 3, 6, 0);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      cmd_valid = 1'b1;
      cmd_x0 = 9'($urandom_range(0, 330)); cmd_y0 = 8'($urandom_range(0, 250));
      cmd_w = 9'($urandom_range(0, 5)); cmd_h = 8'($urandom_range(0, 3));
      cmd_color = 3'($urandom);
    end
    @(negedge clk);
    cmd_valid = 1'b0;
    wait_idle();
    for (int i = 0; i < 12 && i < log_x.size(); i++) begin
      chk("hold_x", log_x[i], 2 + (i % 4));
      chk("hold_y", log_y[i], 3 + (i / 4));
    end

    // Reset during the third pixel of a 4x4 fill.
    clear_logs();
    send(0, 0, 4, 4, 7, 0);
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("rst_wr_en", int'(wr_en), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_ready", int'(cmd_ready), 0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    repeat (10) @(posedge clk);
    #3;
    chk("rst_writes", log_x.size(), 3);

    // Randomized commands.
    for (int n = 0; n < 40; n++) begin
      send($urandom_range(0, 330), $urandom_range(0, 250), $urandom_range(0, 12),
           $urandom_range(0, 8), $urandom_range(0, 7), 0);
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end
    wait_idle();

`ifdef RECT_DRAW_CLEAR_EN
    clear_logs();
    send(50, 50, 3, 3, 0, 1);
    wait_idle();
    chk("clear_count", log_x.size(), XM * YM);
    if (log_x.size() > 0) begin
      chk("clear_last_x", log_x[log_x.size() - 1], 319);
      chk("clear_last_y", log_y[log_y.size() - 1], 239);
    end
    chk("clear_done", done_cnt, 1);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
